ins_mem_multiport: RTL

//  Shared instruction memory for the multicore processor: one program image, CORE_COUNT independent

---
 rtl/ins_mem_pkg.sv | 12 +
 rtl/ins_mem_bank.sv | 39 +++
 rtl/ins_mem_multiport.sv | 113 +++++++++++
 3 files changed

// File: rtl/ins_mem_pkg.sv
// Shared definitions for the multiport instruction memory: FSM state encoding and default widths.
package ins_mem_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_CORE_COUNT = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

endpackage

// File: rtl/ins_mem_bank.sv
// One replica of the program image: single write port, single registered read port.
// Read latency 1 cycle; rdata holds its last value when re_i is low. No backpressure.
module ins_mem_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array left unreset so it maps onto block RAM; only the output register resets.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ins_mem_multiport.sv
// Shared instruction memory: streaming loader writes one image, each core gets its own read port.
// Core reads 1-cycle latency, only while READY; load_ready is a registered state decode (no path from load_valid).
module ins_mem_multiport
  import ins_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CORE_COUNT = DEF_CORE_COUNT
) (
  input  logic                             clock,
  input  logic                             rstN,
  input  logic                             load_start,
  input  logic [ADDR_WIDTH:0]              load_len,
  input  logic                             load_valid,
  input  logic [DATA_WIDTH-1:0]            load_data,
  output logic                             load_ready,
  output logic                             load_done,
  output logic                             prog_ready,
  input  logic [CORE_COUNT-1:0]            core_en,
  input  logic [CORE_COUNT*ADDR_WIDTH-1:0] core_addr,
  output logic [CORE_COUNT*DATA_WIDTH-1:0] core_q,
  output logic [CORE_COUNT-1:0]            core_valid
);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  done_q, done_d;
  logic [CORE_COUNT-1:0] valid_q, valid_d;

  logic start_acc;
  logic accept;
  logic last_word;
  logic rd_ok;

  // A start request while already loading is dropped, as is a zero-length request.
  assign start_acc = load_start && (load_len != '0) && (state_q != ST_LOAD);
  assign accept    = (state_q == ST_LOAD) && load_valid;
  assign last_word = accept && ((cnt_q + 1'b1) == len_q);
  assign rd_ok     = (state_q == ST_READY) && !start_acc;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (start_acc) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          cnt_d    = '0;
          len_d    = load_len;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (last_word) begin
            state_d = ST_READY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done_d  = last_word;
  assign valid_d = rd_ok ? core_en : '0;

  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
    end
  end

  assign load_ready = (state_q == ST_LOAD);
  assign load_done  = done_q;
  assign prog_ready = (state_q == ST_READY);
  assign core_valid = valid_q;

  // Every bank sees the same write stream; bank g serves core g only.
  for (genvar g = 0; g < CORE_COUNT; g++) begin : g_bank
    ins_mem_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk_i  (clock),
      .rst_ni (rstN),
      .we_i   (accept),
      .waddr_i(wr_ptr_q),
      .wdata_i(load_data),
      .re_i   (rd_ok && core_en[g]),
      .raddr_i(core_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .rdata_o(core_q[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
